// File: rtl/shared_mem_arb.sv
// shared_mem_arb: NUM_C independent core ports share one single-port RAM.
// A round-robin arbiter serves one access per cycle. Read data and error
// status come back registered, together with a one-cycle ack pulse.
module shared_mem_arb #(
  parameter int NUM_C = 4,
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_C-1:0]    req,
  input  logic [NUM_C-1:0]    we,
  input  logic [NUM_C*AW-1:0] addr,
  input  logic [NUM_C*DW-1:0] wdata,
  output logic [NUM_C*DW-1:0] rdata,
  output logic [NUM_C-1:0]    ack,
  output logic [NUM_C-1:0]    err
);

  localparam int PW = (NUM_C > 1) ? $clog2(NUM_C) : 1;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_C - 1);

  // Shared storage; deliberately left without reset.
  logic [DW-1:0] mem [DEPTH];

  logic [NUM_C-1:0]    ack_q, ack_d;
  logic [NUM_C-1:0]    err_q, err_d;
  logic [NUM_C*DW-1:0] rdata_q, rdata_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;

  logic [NUM_C-1:0] elig;
  logic             grant_vld;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    cand_idx;
  int               cand;

  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;
  logic          in_range;
  logic          mem_we;
  logic [MW-1:0] mem_idx;

  // Round-robin search starting just after the last granted port. A port
  // is masked in its own ack cycle, so a core that drops req after seeing
  // ack never issues a duplicate access.
  always_comb begin
    elig      = req & ~ack_q;
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_C; k++) begin
      cand     = (int'(rr_ptr_q) + k) % NUM_C;
      cand_idx = PW'(cand);
      if (!grant_vld && elig[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Route the granted port's request to the single RAM port and decode range.
  always_comb begin
    sel_addr  = addr[grant_idx*AW +: AW];
    sel_wdata = wdata[grant_idx*DW +: DW];
    sel_we    = we[grant_idx];
    in_range  = ({1'b0, sel_addr} < DEPTH_W);
    mem_idx   = sel_addr[MW-1:0];
    mem_we    = grant_vld && sel_we && in_range;
  end

  // Next-state for the registered responses and the round-robin pointer.
  // Writes and out-of-range accesses return zero data.
  always_comb begin
    ack_d    = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      ack_d[grant_idx] = 1'b1;
      rr_ptr_d         = grant_idx;
      if (!in_range) begin
        err_d[grant_idx]               = 1'b1;
        rdata_d[grant_idx*DW +: DW]    = '0;
      end else if (sel_we) begin
        rdata_d[grant_idx*DW +: DW]    = '0;
      end else begin
        rdata_d[grant_idx*DW +: DW]    = mem[mem_idx];
      end
    end
  end

  // Response and pointer registers; reset restarts arbitration at port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      rr_ptr_q <= LAST_PORT;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // RAM write port; a grant caught by reset before the edge never writes.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_idx] <= sel_wdata;
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_shared_mem_arb.sv
// Self-checking bench for shared_mem_arb: directed scenarios followed by
// randomized core traffic, all compared against a behavioural model.
module tb_shared_mem_arb;

  localparam int NC    = 4;
  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     req;
  logic [NC-1:0]     we;
  logic [NC*AW-1:0]  addr;
  logic [NC*DW-1:0]  wdata;
  logic [NC*DW-1:0]  rdata;
  logic [NC-1:0]     ack;
  logic [NC-1:0]     err;

  int vector_count = 0;
  int miss_count   = 0;

  // Behavioural model state: expected outputs after the most recent edge.
  logic [NC-1:0]    mdl_ack;
  logic [NC-1:0]    mdl_err;
  logic [DW-1:0]    mdl_rd [NC];
  int               mdl_last;
  logic [DW-1:0]    mdl_mem [int];

  shared_mem_arb #(.NUM_C(NC), .DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vector_count++;
    if (obs !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC*DW-1:0] packRd();
    logic [NC*DW-1:0] v;
    for (int i = 0; i < NC; i++) v[i*DW +: DW] = mdl_rd[i];
    return v;
  endfunction

  task automatic setPort(input int p, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p]          = r;
    we[p]           = w;
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  // One clock cycle: the model decides who is served using the fair
  // rotation rule, then DUT outputs are compared shortly after the edge.
  task automatic applyStimulus();
    int g;
    int p;
    int a;
    g = -1;
    for (int k = 1; k <= NC; k++) begin
      p = (mdl_last + k) % NC;
      if (g < 0 && req[p] && !mdl_ack[p]) g = p;
    end
    mdl_ack = '0;
    mdl_err = '0;
    if (g >= 0) begin
      mdl_last   = g;
      mdl_ack[g] = 1'b1;
      a = int'(addr[g*AW +: AW]);
      if (a >= DEPTH) begin
        mdl_err[g] = 1'b1;
        mdl_rd[g]  = '0;
      end else if (we[g]) begin
        mdl_mem[a] = wdata[g*DW +: DW];
        mdl_rd[g]  = '0;
      end else begin
        mdl_rd[g]  = mdl_mem.exists(a) ? mdl_mem[a] : '0;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("ack",   64'(ack),   64'(mdl_ack));
    checkOutput("err",   64'(err),   64'(mdl_err));
    checkOutput("rdata", 64'(rdata), 64'(packRd()));
    @(negedge clk);
  endtask

  // Asynchronous reset asserted right now, checked immediately, released on a negedge.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ack",   64'(ack),   64'(0));
    checkOutput("rst_err",   64'(err),   64'(0));
    checkOutput("rst_rdata", 64'(rdata), 64'(0));
    mdl_ack  = '0;
    mdl_err  = '0;
    for (int i = 0; i < NC; i++) mdl_rd[i] = '0;
    mdl_last = NC - 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic newRandomReq(input int p);
    logic [AW-1:0] a;
    int sel;
    sel = int'($urandom_range(9, 0));
    if (sel == 0)      a = 16'd1024;
    else if (sel == 1) a = 16'd2000;
    else if (sel == 2) a = 16'hFFFF;
    else               a = AW'($urandom_range(15, 0));
    setPort(p, 1'b1, 1'($urandom_range(1, 0)), a, DW'($urandom));
  endtask

  initial begin
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    rst_n = 1'b1;
    @(negedge clk);
    doReset();

    // Preload the addresses used below so every read has defined data.
    for (int i = 0; i < 17; i++) begin
      setPort(0, 1'b1, 1'b1, (i == 16) ? AW'(976) : AW'(i), DW'($urandom));
      applyStimulus();
      setPort(0, 1'b0, 1'b0, '0, '0);
      applyStimulus();
    end

    // Read after write on port 0.
    setPort(0, 1'b1, 1'b1, 16'd5, 16'h00A5);
    applyStimulus();
    checkOutput("raw_wr_ack", 64'(ack), 64'h1);
    setPort(0, 1'b1, 1'b0, 16'd5, 16'h0);
    applyStimulus();
    checkOutput("raw_mask", 64'(ack), 64'h0);
    applyStimulus();
    checkOutput("raw_rd_ack", 64'(ack), 64'h1);
    checkOutput("raw_rd_data", 64'(rdata[15:0]), 64'h00A5);
    setPort(0, 1'b0, 1'b0, '0, '0);
    applyStimulus();

    // Full contention from reset; port 0 re-requests after its first ack.
    doReset();
    for (int i = 0; i < NC; i++) setPort(i, 1'b1, 1'b0, 16'd5, '0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      checkOutput("contend_ack", 64'(ack), 64'(1 << (c % NC)));
      for (int i = 1; i < NC; i++) if (mdl_ack[i]) req[i] = 1'b0;
    end
    req[0] = 1'b0;

    // Same-address write race with last grant on port 0.
    setPort(1, 1'b1, 1'b1, 16'd10, 16'h1111);
    setPort(2, 1'b1, 1'b1, 16'd10, 16'h2222);
    applyStimulus();
    checkOutput("race_first", 64'(ack), 64'h2);
    req[1] = 1'b0;
    applyStimulus();
    checkOutput("race_second", 64'(ack), 64'h4);
    req[2] = 1'b0;
    setPort(0, 1'b1, 1'b0, 16'd10, '0);
    applyStimulus();
    checkOutput("race_read", 64'(rdata[15:0]), 64'h2222);
    req[0] = 1'b0;
    applyStimulus();

    // Out-of-range read and write on port 3.
    setPort(3, 1'b1, 1'b0, 16'd1024, '0);
    applyStimulus();
    checkOutput("oor_rd_err", 64'(err), 64'h8);
    checkOutput("oor_rd_data", 64'(rdata[63:48]), 64'h0);
    setPort(3, 1'b1, 1'b1, 16'd2000, 16'hBEEF);
    applyStimulus();
    applyStimulus();
    checkOutput("oor_wr_err", 64'(err), 64'h8);
    req[3] = 1'b0;
    setPort(0, 1'b1, 1'b0, 16'd0, '0);
    applyStimulus();
    setPort(0, 1'b1, 1'b0, 16'd976, '0);
    applyStimulus();
    applyStimulus();
    checkOutput("oor_mem976", 64'(rdata[15:0]), 64'(mdl_mem[976]));

    // Held read request on port 0 for six cycles.
    req[0] = 1'b0;
    applyStimulus();
    setPort(0, 1'b1, 1'b0, 16'd5, '0);
    for (int c = 0; c < 6; c++) begin
      applyStimulus();
      checkOutput("held_ack", 64'(ack), 64'((c % 2 == 0) ? 1 : 0));
    end
    req[0] = 1'b0;

    // Reset mid-operation while ports 1 and 2 are pending.
    setPort(1, 1'b1, 1'b0, 16'd3, '0);
    setPort(2, 1'b1, 1'b0, 16'd4, '0);
    #2;
    doReset();
    applyStimulus();
    checkOutput("rst_p1_first", 64'(ack), 64'h2);
    req[1] = 1'b0;
    applyStimulus();
    checkOutput("rst_p2_next", 64'(ack), 64'h4);
    req[2] = 1'b0;
    applyStimulus();

    // Randomized traffic: cores hold requests until acked, then drop or re-issue.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NC; i++) begin
        if (mdl_ack[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else newRandomReq(i);
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          newRandomReq(i);
        end
      end
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
